// File: rtl/blackjack_pkg.sv
// blackjack_pkg: shared arbiter state encodings, state enum and a width helper.
// Latency: none (constants, types and an elaboration-time function only).
// Backpressure: none.
package blackjack_pkg;

    // Arbiter state encodings, kept as plain constants so other blocks can decode them.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OFFER = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        OFFER = ST_OFFER,
        HOLD  = ST_HOLD
    } arb_state_e;

    // Ceiling log2 with a floor of 1, so a 1- or 2-entry range still gets a 1-bit field.
    function automatic int bj_clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/btn_priority_sel.sv
// btn_priority_sel: picks the first set request scanning upward from a start index, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the selection is used.
module btn_priority_sel
    import blackjack_pkg::*;
#(
    parameter int N_BTN = 4,
    parameter int ID_W  = bj_clog2(N_BTN)
) (
    input  logic [N_BTN-1:0] req_i,
    input  logic [ID_W-1:0]  start_i,
    output logic [N_BTN-1:0] onehot_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    // Wrapping scan: the first set bit at or after start_i wins; start_i of 0 gives fixed priority.
    always_comb begin
        int              pos;
        logic [ID_W-1:0] pos_idx;
        logic            found;
        pos      = 0;
        pos_idx  = '0;
        found    = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        for (int i = 0; i < N_BTN; i++) begin
            pos = int'(start_i) + i;
            if (pos >= N_BTN) begin
                pos = pos - N_BTN;
            end
            pos_idx = pos[ID_W-1:0];
            if (!found && req_i[pos_idx]) begin
                found             = 1'b1;
                idx_o             = pos_idx;
                onehot_o[pos_idx] = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/button_arbiter.sv
// button_arbiter: latches button presses and offers one at a time to the game FSM, with post-grant lockout.
// Latency: press to o_Valid is 2 cycles from IDLE; lockout after accept is HOLDOFF cycles.
// Backpressure: o_Valid/o_BtnId held stable until i_Ready; presses keep latching meanwhile (BUTTON_ARBITER_RR_EN selects round-robin).
module button_arbiter
    import blackjack_pkg::*;
#(
    parameter int N_BTN   = 4,
    parameter int HOLDOFF = 200
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst_n,
    input  logic [N_BTN-1:0]           i_BtnDown,
    input  logic                       i_Ready,
    output logic                       o_Valid,
    output logic [bj_clog2(N_BTN)-1:0] o_BtnId,
    output logic [N_BTN-1:0]           o_Pending,
    output logic                       o_Overrun
);

    localparam int ID_W  = bj_clog2(N_BTN);
    localparam int CNT_W = bj_clog2(HOLDOFF + 1);
    // Counter is loaded one short because the first HOLD cycle already counts toward the lockout.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);

    arb_state_e       state_q,   state_d;
    logic             valid_q,   valid_d;
    logic [ID_W-1:0]  id_q,      id_d;
    logic [N_BTN-1:0] gnt_oh_q,  gnt_oh_d;
    logic [N_BTN-1:0] pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic             accept;
    logic [N_BTN-1:0] acc_mask;
    logic [ID_W-1:0]  sel_start;
    logic [N_BTN-1:0] sel_oh;
    logic [ID_W-1:0]  sel_idx;
    logic             sel_any;

    assign accept   = valid_q && i_Ready;
    assign acc_mask = accept ? gnt_oh_q : '0;

`ifdef BUTTON_ARBITER_RR_EN
    logic [ID_W-1:0] ptr_q, ptr_d;

    // Round-robin pointer moves to the slot just after the most recently accepted button.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            if (id_q == ID_W'(N_BTN - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = id_q + ID_W'(1);
            end
        end
    end

    // Pointer register; reset to 0 so the first search after reset is lowest-index first.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign sel_start = ptr_q;
`else
    assign sel_start = '0;
`endif

    btn_priority_sel #(
        .N_BTN (N_BTN),
        .ID_W  (ID_W)
    ) u_sel (
        .req_i    (pending_q),
        .start_i  (sel_start),
        .onehot_o (sel_oh),
        .idx_o    (sel_idx),
        .any_o    (sel_any)
    );

    // Next-state logic: request latching runs in every state, the FSM only gates the offer.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        id_d      = id_q;
        gnt_oh_d  = gnt_oh_q;
        cnt_d     = cnt_q;
        // A press on the bit being accepted re-sets it, so the set term is applied after the clear.
        pending_d = (pending_q & ~acc_mask) | i_BtnDown;
        // Only a press landing on a bit that stays pending is lost; the accepted bit does not count.
        overrun_d = |(i_BtnDown & pending_q & ~acc_mask);

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (sel_any) begin
                    id_d     = sel_idx;
                    gnt_oh_d = sel_oh;
                    valid_d  = 1'b1;
                    state_d  = OFFER;
                end
            end
            OFFER: begin
                // Winner is frozen here; new presses only update the pending vector.
                if (i_Ready) begin
                    valid_d = 1'b0;
                    if (HOLDOFF == 0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = HOLD_LOAD;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                valid_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                valid_d = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset also drops any presses arriving during reset.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            id_q      <= '0;
            gnt_oh_q  <= '0;
            pending_q <= '0;
            overrun_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            gnt_oh_q  <= gnt_oh_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_Valid   = valid_q;
    assign o_BtnId   = id_q;
    assign o_Pending = pending_q;
    assign o_Overrun = overrun_q;

endmodule

// File: tb/tb_button_arbiter.sv
// tb_button_arbiter: scoreboard bench for button_arbiter (HOLDOFF=4 main instance, HOLDOFF=0 side instance).
// Latency: checks press-to-offer, lockout gap and back-to-back offers.
// Backpressure: drives i_Ready low to hold offers and verifies stability and overrun pulses.
module tb_button_arbiter;

    localparam int N = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [N-1:0] btn;
    logic         rdy;

    logic         v, ovr;
    logic [1:0]   id;
    logic [N-1:0] pend;

    logic         v0, ovr0;
    logic [1:0]   id0;
    logic [N-1:0] pend0;

    button_arbiter #(.N_BTN(N), .HOLDOFF(H)) dut (
        .i_Clk     (clk),
        .i_Rst_n   (rst_n),
        .i_BtnDown (btn),
        .i_Ready   (rdy),
        .o_Valid   (v),
        .o_BtnId   (id),
        .o_Pending (pend),
        .o_Overrun (ovr)
    );

    button_arbiter #(.N_BTN(N), .HOLDOFF(0)) dut0 (
        .i_Clk     (clk),
        .i_Rst_n   (rst_n),
        .i_BtnDown (btn),
        .i_Ready   (rdy),
        .o_Valid   (v0),
        .o_BtnId   (id0),
        .o_Pending (pend0),
        .o_Overrun (ovr0)
    );

    int   n_tests   = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   acc_edge  = -1;
    int   rise_edge = -1;
    int   last_gap  = -1;
    int   rise_cnt  = 0;
    int   ovr_cnt   = 0;
    logic prev_v    = 1'b0;
    int   sbq[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: score an accept due at this edge, advance, then sample outputs at the negedge.
    task automatic step();
        int exp_id;
        if (v === 1'b1 && rdy === 1'b1) begin
            acc_edge = cyc + 1;
            if (sbq.size() == 0) begin
                chk("sb_unexpected_grant", {30'd0, id}, 32'hFFFF_FFFF);
            end else begin
                exp_id = sbq.pop_front();
                chk("sb_grant_id", {30'd0, id}, exp_id);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        btn = '0;
        if (v === 1'b1 && prev_v !== 1'b1) begin
            rise_edge = cyc;
            rise_cnt++;
            if (acc_edge >= 0) last_gap = cyc - acc_edge;
        end
        if (ovr === 1'b1) ovr_cnt++;
        prev_v = v;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 60 && sbq.size() != 0; k++) step();
        chk({tag, "_drain"}, sbq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int r0;
        int o0;
        rst_n = 1'b0;
        btn   = '0;
        rdy   = 1'b0;
        step();
        step();
        chk("rst_valid", v, 0);
        chk("rst_id", id, 0);
        chk("rst_pend", pend, 0);
        chk("rst_ovr", ovr, 0);
        rst_n = 1'b1;
        step();

        // Single press, ready high: 2-cycle latency, pending cleared after accept, no re-offer.
        rdy = 1'b1;
        btn = 4'b0100;
        sbq.push_back(2);
        p = cyc + 1;
        step();
        chk("t1_latch_pend", pend, 4'b0100);
        chk("t1_latch_valid", v, 0);
        step();
        chk("t1_offer_valid", v, 1);
        chk("t1_offer_id", id, 2);
        chk("t1_latency", rise_edge - p, 1);
        step();
        chk("t1_pend_clear", pend, 0);
        chk("t1_valid_drop", v, 0);
        r0 = rise_cnt;
        repeat (10) step();
        chk("t1_no_reoffer", rise_cnt - r0, 0);

        // Two simultaneous presses: order depends on arbitration mode, gap is the lockout.
        btn = 4'b1010;
`ifdef BUTTON_ARBITER_RR_EN
        sbq.push_back(3);
        sbq.push_back(1);
`else
        sbq.push_back(1);
        sbq.push_back(3);
`endif
        drain("t2");
        chk("t2_lockout_gap", last_gap, H + 1);
        repeat (8) step();

        // Offer held with ready low while bit 0 is hammered.
        rdy = 1'b0;
        btn = 4'b0010;
        sbq.push_back(1);
        step();
        step();
        chk("t3_offer_valid", v, 1);
        o0 = ovr_cnt;
        for (int k = 0; k < 10; k++) begin
            btn = 4'b0001;
            step();
            chk("t3_hold_valid", v, 1);
            chk("t3_hold_id", id, 1);
        end
        chk("t3_overrun_cnt", ovr_cnt - o0, 9);
        chk("t3_pend", pend, 4'b0011);
        rdy = 1'b1;
        sbq.push_back(0);
        drain("t3");
        repeat (8) step();
        chk("t3_pend_empty", pend, 0);

        // Press on the bit being accepted: set wins, no overrun, re-offered after lockout.
        rdy = 1'b0;
        btn = 4'b0100;
        sbq.push_back(2);
        step();
        step();
        chk("t4_offer_id", id, 2);
        rdy = 1'b1;
        btn = 4'b0100;
        o0  = ovr_cnt;
        step();
        chk("t4_pend_kept", pend, 4'b0100);
        chk("t4_valid_drop", v, 0);
        chk("t4_no_overrun", ovr_cnt - o0, 0);
        sbq.push_back(2);
        drain("t4");
        chk("t4_reoffer_gap", last_gap, H + 1);
        repeat (8) step();

        // Reset mid-HOLD with two pending bits; press during reset is discarded.
        rdy = 1'b0;
        btn = 4'b0011;
        sbq.push_back(0);
        step();
        step();
        chk("t5_offer_id", id, 0);
        rdy = 1'b1;
        btn = 4'b0001;
        step();
        step();
        chk("t5_hold_pend", pend, 4'b0011);
        chk("t5_hold_valid", v, 0);
        rst_n = 1'b0;
        btn   = 4'b1000;
        step();
        rst_n = 1'b1;
        chk("t5_rst_valid", v, 0);
        chk("t5_rst_id", id, 0);
        chk("t5_rst_pend", pend, 0);
        chk("t5_rst_ovr", ovr, 0);
        r0 = rise_cnt;
        repeat (10) step();
        chk("t5_no_offer", rise_cnt - r0, 0);
        chk("t5_pend_idle", pend, 0);
        chk("t5_sb_empty", sbq.size(), 0);

        // HOLDOFF=0 instance: back-to-back offers with one idle cycle between.
        rdy = 1'b1;
        btn = 4'b0011;
        sbq.push_back(0);
        sbq.push_back(1);
        step();
        chk("t6_h0_latch_valid", v0, 0);
        chk("t6_h0_latch_pend", pend0, 4'b0011);
        step();
        chk("t6_h0_offer0_valid", v0, 1);
        chk("t6_h0_offer0_id", id0, 0);
        step();
        chk("t6_h0_idle_valid", v0, 0);
        chk("t6_h0_idle_pend", pend0, 4'b0010);
        step();
        chk("t6_h0_offer1_valid", v0, 1);
        chk("t6_h0_offer1_id", id0, 1);
        step();
        chk("t6_h0_done_valid", v0, 0);
        chk("t6_h0_done_pend", pend0, 0);
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
